// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Optional build macro: MUX_ARB_FIXED_PRIO_EN (see rr_pick).
package mux_arb_pkg;
  localparam int DATA_W = 4;
  localparam int N_SRC  = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {IDLE, SELECT, HOLD} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_4to1.sv
// 4-source combinational word mux driven by the arbiter select.
module mux_4to1 #(
  parameter int DATA_W = 4
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] out
);
  always_comb begin
    out = a;
    case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      default: out = d;
    endcase
  end
endmodule

// File: rtl/rr_pick.sv
// Combinational winner selection: rotating scan from ptr+1, or lowest index
// when MUX_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  sel_t             ptr,
  output sel_t             winner,
  output logic             any
);
  always_comb begin
    winner = ptr;
    any    = |req;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) winner = sel_t'(i);
    end
`else
    // Walk the scan order backwards so the earliest candidate is written last.
    for (int i = N_SRC; i >= 1; i--) begin
      sel_t idx;
      idx = ptr + sel_t'(i);
      if (req[idx]) winner = idx;
    end
`endif
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler for mux_4to1: drives sel, captures the word, and
// presents it on a valid/ready port. Build option: MUX_ARB_FIXED_PRIO_EN.
module mux_rr_arbiter #(
  parameter int DATA_W = mux_arb_pkg::DATA_W,
  parameter int N_SRC  = mux_arb_pkg::N_SRC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  req,
  output logic [N_SRC-1:0]  grant,
  output logic [1:0]        sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  import mux_arb_pkg::*;

  arb_state_t state, state_nxt;
  sel_t       ptr;
  sel_t       winner;
  logic       any;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = SELECT;
      SELECT:  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select, pointer and output port registers; grant is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      ptr       <= sel_t'(N_SRC - 1);
      grant     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (any) sel <= winner;
        end
        SELECT: begin
          out_data   <= mux_out;
          out_valid  <= 1'b1;
          grant[sel] <= 1'b1;
`ifndef MUX_ARB_FIXED_PRIO_EN
          ptr        <= sel;
`endif
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter driving mux_4to1 with sources A..D.
module tb_mux_rr_arbiter;
`ifdef MUX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [3:0] mux_out;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;

  always #5 clk = ~clk;

  mux_4to1 #(.DATA_W(4)) u_mux (
    .sel (sel),
    .a   (4'hA),
    .b   (4'hB),
    .c   (4'hC),
    .d   (4'hD),
    .out (mux_out)
  );

  mux_rr_arbiter #(.DATA_W(4), .N_SRC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] d;
    logic [1:0] s;
  } exp_t;

  exp_t sb[$];
  int   gcyc[$];
  int   checks = 0;
  int   failures = 0;
  int   gcount = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] d, input logic [1:0] s);
    exp_t e;
    e.g = g;
    e.d = d;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n;
    n = 0;
    while (gcount < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_wait", 32'(gcount >= target), 32'd1);
  endtask

  // Monitor: every grant pulse must match the next queued transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (|grant) === 1'b1) begin
      exp_t e;
      gcount++;
      gcyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant actual=%b expected=none", grant);
      end else begin
        e = sb.pop_front();
        chk("grant",     32'(grant),     32'(e.g));
        chk("out_data",  32'(out_data),  32'(e.d));
        chk("sel",       32'(sel),       32'(e.s));
        chk("out_valid", 32'(out_valid), 32'd1);
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_grant", 32'(grant),     32'd0);
    chk("rst_sel",   32'(sel),       32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    rst_n = 1'b1;
    step(1);

    // All four requests held: rotation 0,1,2,3,0, one word per three cycles.
    if (FIXED) repeat (5) push(4'b0001, 4'hA, 2'd0);
    else begin
      push(4'b0001, 4'hA, 2'd0);
      push(4'b0010, 4'hB, 2'd1);
      push(4'b0100, 4'hC, 2'd2);
      push(4'b1000, 4'hD, 2'd3);
      push(4'b0001, 4'hA, 2'd0);
    end
    req = 4'b1111;
    wait_grants(5, 40);
    req = 4'b0;
    if (gcyc.size() >= 5) chk("rr_spacing", 32'(gcyc[4] - gcyc[0]), 32'd12);
    step(1);
    chk("all_idle_valid", 32'(out_valid), 32'd0);

    // Single source: sel one cycle after the request, grant the cycle after.
    push(4'b0100, 4'hC, 2'd2);
    req = 4'b0100;
    step(1);
    chk("single_sel", 32'(sel), 32'd2);
    chk("single_nogrant", 32'(grant), 32'd0);
    wait_grants(6, 10);
    req = 4'b0;
    step(1);
    chk("single_idle", 32'(out_valid), 32'd0);

    // Backpressure: five stalled HOLD cycles, then accept.
    out_ready = 1'b0;
    push(4'b0001, 4'hA, 2'd0);
    req = 4'b0001;
    wait_grants(7, 10);
    req = 4'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'hA);
      chk("bp_sel",   32'(sel),       32'd0);
      chk("bp_grant", 32'(grant),     32'd0);
    end
    out_ready = 1'b1;
    step(1);
    chk("bp_release", 32'(out_valid), 32'd0);

    // Request change during SELECT is ignored until the next IDLE.
    push(4'b0010, 4'hB, 2'd1);
    if (FIXED) push(4'b0001, 4'hA, 2'd0);
    else       push(4'b1000, 4'hD, 2'd3);
    req = 4'b0010;
    step(1);
    req = 4'b1001;
    wait_grants(9, 20);
    req = 4'b0;
    step(1);
    chk("mid_idle", 32'(out_valid), 32'd0);

    // Ten idle cycles: nothing moves.
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_grant", 32'(grant),     32'd0);
      chk("idle_sel",   32'(sel),       FIXED ? 32'd0 : 32'd3);
    end

    // Reset while a word is held.
    out_ready = 1'b0;
    push(4'b1000, 4'hD, 2'd3);
    req = 4'b1000;
    wait_grants(10, 10);
    req = 4'b0;
    step(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_grant", 32'(grant),     32'd0);
    chk("midrst_sel",   32'(sel),       32'd0);
    step(1);
    rst_n = 1'b1;
    push(4'b1000, 4'hD, 2'd3);
    req = 4'b1000;
    step(1);
    chk("post_rst_sel", 32'(sel), 32'd3);
    wait_grants(11, 10);
    chk("post_rst_data", 32'(out_data), 32'hD);
    req = 4'b0;
    out_ready = 1'b1;
    step(2);
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
